alu_execute: RTL and testbench

ALU_EXECUTE -- requirements
Module: alu_execute

---
 rtl/alu_execute.sv | 138 +++++++++++++
 tb/tb_alu_execute.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_execute.sv
// Single-issue ALU execute stage with valid/ready handshakes on both sides.
// Single-cycle ops finish in one cycle; MUL runs an iterative shift-add over WIDTH cycles.
module alu_execute #(
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               alu_control,
    input  logic                     regwrite_control,
    input  logic [WIDTH-1:0]         rs1_data,
    input  logic [WIDTH-1:0]         rs2_data,
    input  logic [4:0]               rd_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic [4:0]               rd_out,
    output logic                     regwrite_out,
    output logic                     zero,
    output logic                     illegal
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_rd_out;
    logic             r_regwrite;
    logic             r_illegal;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [SW-1:0]    r_count;
    logic             r_wr_mul;

    logic [WIDTH-1:0] w_alu_result;
    logic             w_illegal;
    logic             w_wr;
    logic             w_accept;
    logic [SW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_partial;

    assign w_shamt   = rs2_data[SW-1:0];
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_wr      = regwrite_control && (rd_addr != 5'd0) && !w_illegal;
    assign w_partial = r_acc + (r_mplier[0] ? r_mcand : '0);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        w_alu_result = '0;
        w_illegal    = 1'b0;
        case (alu_control)
            4'b0000: w_alu_result = rs1_data & rs2_data;
            4'b0001: w_alu_result = rs1_data | rs2_data;
            4'b0010: w_alu_result = rs1_data + rs2_data;
            4'b0011: w_alu_result = rs1_data << w_shamt;
            4'b0100: w_alu_result = rs1_data - rs2_data;
            4'b0101: w_alu_result = rs1_data >> w_shamt;
            4'b0110: w_alu_result = '0;
            4'b0111: w_alu_result = rs1_data ^ rs2_data;
            default: w_illegal    = 1'b1;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_rd_out    <= '0;
            r_regwrite  <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_count     <= '0;
            r_wr_mul    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rd_out <= rd_addr;
                        if (alu_control == 4'b0110) begin
                            r_acc    <= '0;
                            r_mcand  <= rs1_data;
                            r_mplier <= rs2_data;
                            r_count  <= '0;
                            r_wr_mul <= w_wr;
                            r_state  <= MUL;
                        end else begin
                            r_result    <= w_alu_result;
                            r_illegal   <= w_illegal;
                            r_regwrite  <= w_wr;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                MUL: begin
                    // One multiplier bit per cycle; the final partial sum is the product.
                    r_acc    <= w_partial;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + SW'(1);
                    if (r_count == LAST) begin
                        r_result    <= w_partial;
                        r_regwrite  <= r_wr_mul;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_regwrite  <= 1'b0;
                        r_illegal   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = r_out_valid;
    assign result       = r_result;
    assign rd_out       = r_rd_out;
    assign regwrite_out = r_regwrite;
    assign illegal      = r_illegal;
    assign zero         = (r_result == '0);

endmodule

// File: tb/tb_alu_execute.sv
// Directed bench for alu_execute: inputs driven and outputs sampled on the falling edge.
module tb_alu_execute;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic        regwrite_control;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        regwrite_out;
    logic        zero;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    alu_execute #(.WIDTH(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .alu_control      (alu_control),
        .regwrite_control (regwrite_control),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .rd_addr          (rd_addr),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .rd_out           (rd_out),
        .regwrite_out     (regwrite_out),
        .zero             (zero),
        .illegal          (illegal)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one operation at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic wr);
        alu_control      = op;
        rs1_data         = a;
        rs2_data         = b;
        rd_addr          = rd;
        regwrite_control = wr;
        in_valid         = 1'b1;
        @(negedge clock);
        in_valid         = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic [31:0] res, input logic [4:0] rd,
                              input logic wr, input logic ill);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, result, res);
        check({tag, "_zero"}, 32'(zero), 32'(res == 32'd0));
        check({tag, "_rd"}, 32'(rd_out), 32'(rd));
        check({tag, "_wr"}, 32'(regwrite_out), 32'(wr));
        check({tag, "_illegal"}, 32'(illegal), 32'(ill));
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        reset            = 1'b0;
        in_valid         = 1'b0;
        out_ready        = 1'b1;
        alu_control      = 4'd0;
        regwrite_control = 1'b0;
        rs1_data         = 32'd0;
        rs2_data         = 32'd0;
        rd_addr          = 5'd0;

        // Values held during reset
        @(negedge clock);
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_wr", 32'(regwrite_out), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        // ADD wrap, accepted at the first rising edge after release
        reset = 1'b1;
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
        check_done("add_wrap", 32'd0, 5'd5, 1'b1, 1'b0);
        @(negedge clock);
        check("add_back_idle", 32'(in_ready), 32'd1);
        check("add_valid_clr", 32'(out_valid), 32'd0);

        issue(4'b0100, 32'd3, 32'd5, 5'd7, 1'b1);
        check_done("sub", 32'hFFFF_FFFE, 5'd7, 1'b1, 1'b0);
        @(negedge clock);
        issue(4'b0011, 32'd1, 32'd33, 5'd8, 1'b1);
        check_done("sll", 32'h0000_0002, 5'd8, 1'b1, 1'b0);
        @(negedge clock);
        issue(4'b0101, 32'h8000_0000, 32'd31, 5'd9, 1'b1);
        check_done("srl", 32'h0000_0001, 5'd9, 1'b1, 1'b0);
        @(negedge clock);
        issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd10, 1'b0);
        check_done("and", 32'h0000_F000, 5'd10, 1'b0, 1'b0);
        @(negedge clock);
        issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 5'd11, 1'b1);
        check_done("or", 32'h0000_FFF0, 5'd11, 1'b1, 1'b0);
        @(negedge clock);

        // MUL: busy for 32 cycles, result on cycle 33
        issue(4'b0110, 32'h0001_0000, 32'h0001_0003, 5'd3, 1'b1);
        for (int i = 1; i <= 32; i++) begin
            check($sformatf("mul_busy%0d", i), {30'd0, in_ready, out_valid}, 32'd0);
            if (i == 5) check("mul_wr_low", 32'(regwrite_out), 32'd0);
            @(negedge clock);
        end
        check_done("mul", 32'h0003_0000, 5'd3, 1'b1, 1'b0);
        @(negedge clock);
        issue(4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1);
        repeat (32) @(negedge clock);
        check_done("mul_wrap", 32'h0000_0001, 5'd4, 1'b1, 1'b0);
        @(negedge clock);
        issue(4'b0110, 32'd7, 32'd6, 5'd0, 1'b1);
        repeat (32) @(negedge clock);
        check_done("mul_small", 32'd42, 5'd0, 1'b0, 1'b0);
        @(negedge clock);

        // rd=0 suppresses writeback; undefined code flags illegal
        issue(4'b0111, 32'h0000_AAAA, 32'h0000_5555, 5'd0, 1'b1);
        check_done("xor_rd0", 32'h0000_FFFF, 5'd0, 1'b0, 1'b0);
        @(negedge clock);
        issue(4'b1010, 32'h1234_5678, 32'h1111_1111, 5'd6, 1'b1);
        check_done("illegal", 32'd0, 5'd6, 1'b0, 1'b1);
        @(negedge clock);
        check("illegal_clr", 32'(illegal), 32'd0);

        // Backpressure: outputs hold while inputs churn
        out_ready = 1'b0;
        issue(4'b0010, 32'd100, 32'd23, 5'd12, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid    = 1'b1;
            alu_control = 4'(i);
            rs1_data    = 32'(i * 1000);
            rs2_data    = 32'(i + 77);
            rd_addr     = 5'(i + 20);
            @(negedge clock);
            check_done($sformatf("hold%0d", i), 32'd123, 5'd12, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("hold_release_ready", 32'(in_ready), 32'd1);
        check("hold_release_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        @(negedge clock);
        check("no_same_cycle_accept", 32'(out_valid), 32'd0);

        // Reset part-way through a MUL
        issue(4'b0110, 32'd9, 32'd9, 5'd2, 1'b1);
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_result", result, 32'd0);
        check("mrst_zero", 32'(zero), 32'd1);
        check("mrst_rd", 32'(rd_out), 32'd0);
        check("mrst_wr", 32'(regwrite_out), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            check($sformatf("mrst_quiet%0d", i), 32'(out_valid), 32'd0);
        end
        issue(4'b0010, 32'd2, 32'd2, 5'd1, 1'b1);
        check_done("add_after_rst", 32'd4, 5'd1, 1'b1, 1'b0);
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
